// File: rtl/idli_nibble_ser_m.sv
// Instruction nibble serializer: streams a 16-bit instruction word, plus an optional
// 16-bit immediate, one nibble per cycle towards the decoder.
// Optional feature macro: IDLI_SER_PARITY_EN adds o_ser_par, the instruction parity bit
// shown alongside the final nibble of each instruction.
module idli_nibble_ser_m #(
   parameter bit          LSB_FIRST = 1'b1,
   parameter int unsigned GAP       = 0
) (
   input  logic        i_ser_gck,
   input  logic        i_ser_rst,
   input  logic [15:0] i_ser_ins,
   input  logic [15:0] i_ser_imm,
   input  logic        i_ser_has_imm,
   input  logic        i_ser_ins_vld,
   output logic        o_ser_ins_rdy,
   output logic [3:0]  o_ser_enc,
   output logic        o_ser_enc_vld,
   input  logic        i_ser_enc_rdy,
   output logic        o_ser_sot,
`ifdef IDLI_SER_PARITY_EN
   output logic        o_ser_par,
`endif
   output logic        o_ser_busy
);

   typedef enum logic [1:0] {StIdle, StIns, StImm, StGap} state_e;

   localparam bit NoGap = (GAP == 0);
   // The IDLE cycle that accepts the next word is the last of the GAP idle cycles,
   // so the GAP state itself only lasts GAP-1 cycles.
   localparam logic [2:0] GapLast = (GAP > 1) ? 3'(GAP - 2) : 3'd0;

   state_e      state_q;
   logic [1:0]  cnt_q;
   logic [2:0]  gap_cnt_q;
   logic [15:0] ins_q;
   logic [15:0] imm_q;
   logic        has_imm_q;
   logic [3:0]  enc_q;
   logic        vld_q;
   logic        sot_q;
   logic        busy_q;

   logic xfer;
   logic last_nib;
   logic ins_rdy;
   logic accept;

   // Nibble idx of a word in stream order.
   function automatic logic [3:0] nib(input logic [15:0] w, input logic [1:0] idx);
      logic [1:0] k;
      k = LSB_FIRST ? idx : 2'd3 - idx;
      unique case (k)
         2'd0:    return w[3:0];
         2'd1:    return w[7:4];
         2'd2:    return w[11:8];
         default: return w[15:12];
      endcase
   endfunction

   // Handshakes; ready may rise during the final nibble transfer for a bubble-free stream.
   always_comb begin
      xfer     = vld_q && i_ser_enc_rdy;
      last_nib = (cnt_q == 2'd3) &&
                 ((state_q == StIns && !has_imm_q) || state_q == StImm);
      ins_rdy  = (state_q == StIdle) || (NoGap && xfer && last_nib);
      accept   = i_ser_ins_vld && ins_rdy;
   end

   // Serializer FSM with registered nibble outputs.
   always_ff @(posedge i_ser_gck) begin
      if (i_ser_rst) begin
         state_q   <= StIdle;
         cnt_q     <= 2'd0;
         gap_cnt_q <= 3'd0;
         ins_q     <= 16'h0;
         imm_q     <= 16'h0;
         has_imm_q <= 1'b0;
         enc_q     <= 4'h0;
         vld_q     <= 1'b0;
         sot_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else if (accept) begin
         state_q   <= StIns;
         cnt_q     <= 2'd0;
         ins_q     <= i_ser_ins;
         imm_q     <= i_ser_imm;
         has_imm_q <= i_ser_has_imm;
         enc_q     <= nib(i_ser_ins, 2'd0);
         vld_q     <= 1'b1;
         sot_q     <= 1'b1;
         busy_q    <= 1'b1;
      end else begin
         unique case (state_q)
            StIdle: ;
            StIns, StImm: begin
               if (xfer) begin
                  sot_q <= 1'b0;
                  if (cnt_q != 2'd3) begin
                     cnt_q <= cnt_q + 2'd1;
                     enc_q <= nib((state_q == StIns) ? ins_q : imm_q, cnt_q + 2'd1);
                  end else if (state_q == StIns && has_imm_q) begin
                     state_q <= StImm;
                     cnt_q   <= 2'd0;
                     enc_q   <= nib(imm_q, 2'd0);
                  end else if (GAP > 1) begin
                     state_q   <= StGap;
                     cnt_q     <= 2'd0;
                     gap_cnt_q <= 3'd0;
                     enc_q     <= 4'h0;
                     vld_q     <= 1'b0;
                  end else begin
                     state_q <= StIdle;
                     cnt_q   <= 2'd0;
                     enc_q   <= 4'h0;
                     vld_q   <= 1'b0;
                     busy_q  <= 1'b0;
                  end
               end
            end
            StGap: begin
               if (gap_cnt_q == GapLast) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else begin
                  gap_cnt_q <= gap_cnt_q + 3'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign o_ser_ins_rdy = ins_rdy;
   assign o_ser_enc     = enc_q;
   assign o_ser_enc_vld = vld_q;
   assign o_ser_sot     = sot_q;
   assign o_ser_busy    = busy_q;

`ifdef IDLI_SER_PARITY_EN
   logic par_q;
   logic fin_nxt;

   // Next nibble shown is the final one of the instruction.
   assign fin_nxt = xfer && (cnt_q == 2'd2) &&
                    (state_q == StImm || (state_q == StIns && !has_imm_q));

   // Parity is raised with the final nibble and held through any stall on it.
   always_ff @(posedge i_ser_gck) begin
      if (i_ser_rst) begin
         par_q <= 1'b0;
      end else if (accept) begin
         par_q <= 1'b0;
      end else if (fin_nxt) begin
         par_q <= (^ins_q) ^ (has_imm_q & (^imm_q));
      end else if (xfer) begin
         par_q <= 1'b0;
      end
   end

   assign o_ser_par = par_q;
`endif

endmodule

// File: tb/tb_idli_nibble_ser_m.sv
// Bench for idli_nibble_ser_m: three instances (LSB/GAP0, MSB/GAP0, LSB/GAP2) share stimulus.
// Directed vector table plus random traffic, all checked against a queue-based model.
module tb_idli_nibble_ser_m;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1, ins_vld = 1'b0, has_imm = 1'b0, enc_rdy = 1'b1;
   logic [15:0] ins = 16'h0, imm = 16'h0;
   logic        rdy_w  [3];
   logic [3:0]  enc_w  [3];
   logic        vld_w  [3];
   logic        sot_w  [3];
   logic        busy_w [3];
   logic        par_w  [3];

`ifdef IDLI_SER_PARITY_EN
   localparam bit ParEn = 1'b1;
`else
   localparam bit ParEn = 1'b0;
`endif

   for (genvar g = 0; g < 3; g++) begin : g_dut
      idli_nibble_ser_m #(
         .LSB_FIRST (g != 1),
         .GAP       ((g == 2) ? 2 : 0)
      ) u_dut (
         .i_ser_gck     (clk),
         .i_ser_rst     (rst),
         .i_ser_ins     (ins),
         .i_ser_imm     (imm),
         .i_ser_has_imm (has_imm),
         .i_ser_ins_vld (ins_vld),
         .o_ser_ins_rdy (rdy_w[g]),
         .o_ser_enc     (enc_w[g]),
         .o_ser_enc_vld (vld_w[g]),
         .i_ser_enc_rdy (enc_rdy),
         .o_ser_sot     (sot_w[g]),
`ifdef IDLI_SER_PARITY_EN
         .o_ser_par     (par_w[g]),
`endif
         .o_ser_busy    (busy_w[g])
      );
`ifndef IDLI_SER_PARITY_EN
      assign par_w[g] = 1'b0;
`endif
   end

   typedef struct {
      int          k;
      bit          rst, vld, has, rdy, chk;
      logic [15:0] ins, imm;
      bit          e_vld, e_sot, e_rdy, e_busy, e_par;
      logic [3:0]  e_enc;
   } vec_t;

   vec_t vecs[$];
   int   n_chk = 0, n_err = 0;

   // Reference model: per-instance queue of nibbles still to be shown.
   logic [3:0] mq [3][$];
   int         gap_left [3];
   bit         mfirst [3];
   bit         mpar [3];
   bit         started = 1'b0;
   bit         prev_rst = 1'b0;

   function automatic int gap_of(input int k);
      return (k == 2) ? 2 : 0;
   endfunction

   function automatic logic [3:0] nib_of(input logic [15:0] w, input int i, input bit lsb);
      int sh;
      sh = lsb ? 4 * i : 4 * (3 - i);
      return 4'((w >> sh) & 16'hF);
   endfunction

   task automatic r(input int k, input bit rst_v, input bit vld, input logic [15:0] w,
                    input bit has, input logic [15:0] im, input bit rdy, input bit chk,
                    input bit ev, input logic [3:0] ee, input bit es, input bit er,
                    input bit eb, input bit ep);
      vec_t v;
      v.k = k; v.rst = rst_v; v.vld = vld; v.ins = w; v.has = has; v.imm = im;
      v.rdy = rdy; v.chk = chk; v.e_vld = ev; v.e_enc = ee; v.e_sot = es;
      v.e_rdy = er; v.e_busy = eb; v.e_par = ep;
      vecs.push_back(v);
   endtask

   task automatic rs(input int k);
      r(k, 1, 0, 16'h0, 0, 16'h0, 1, 0, 0, 4'h0, 0, 0, 0, 0);
   endtask

   task automatic x(input int k, input bit vld, input logic [15:0] w, input bit has,
                    input logic [15:0] im, input bit rdy, input bit ev, input logic [3:0] ee,
                    input bit es, input bit er, input bit eb, input bit ep);
      r(k, 0, vld, w, has, im, rdy, 1, ev, ee, es, er, eb, ep);
   endtask

   // Apply one cycle of stimulus, check, advance the model, move to the next cycle.
   task automatic step(input vec_t v, input int idx);
      bit         pv, ps, pr, pb, pp, xf, ac, ep;
      logic [3:0] pe;
      int         k;
      rst = v.rst; ins_vld = v.vld; ins = v.ins; has_imm = v.has; imm = v.imm;
      enc_rdy = v.rdy;
      #1;
      if (v.chk) begin
         k  = v.k;
         ep = ParEn & v.e_par;
         n_chk++;
         if (vld_w[k] !== v.e_vld || ((v.e_vld || prev_rst) && enc_w[k] !== v.e_enc) ||
             sot_w[k] !== v.e_sot || rdy_w[k] !== v.e_rdy || busy_w[k] !== v.e_busy ||
             par_w[k] !== ep) begin
            n_err++;
            $display("FAIL vec%0d dut%0d: got vld=%b enc=%h sot=%b rdy=%b busy=%b par=%b, want vld=%b enc=%h sot=%b rdy=%b busy=%b par=%b",
                     idx, k, vld_w[k], enc_w[k], sot_w[k], rdy_w[k], busy_w[k], par_w[k],
                     v.e_vld, v.e_enc, v.e_sot, v.e_rdy, v.e_busy, ep);
         end
      end
      for (int m = 0; m < 3; m++) begin
         pv = mq[m].size() > 0;
         pe = pv ? mq[m][0] : 4'h0;
         ps = pv && mfirst[m];
         pb = pv || (gap_left[m] > 0);
         pr = (!pv && gap_left[m] == 0) || (gap_of(m) == 0 && mq[m].size() == 1 && v.rdy);
         pp = ParEn && pv && mq[m].size() == 1 && mpar[m];
         if (started) begin
            n_chk++;
            if (vld_w[m] !== pv || (pv && enc_w[m] !== pe) || sot_w[m] !== ps ||
                rdy_w[m] !== pr || busy_w[m] !== pb || par_w[m] !== pp) begin
               n_err++;
               $display("FAIL model dut%0d t=%0t: got vld=%b enc=%h sot=%b rdy=%b busy=%b par=%b, want vld=%b enc=%h sot=%b rdy=%b busy=%b par=%b",
                        m, $time, vld_w[m], enc_w[m], sot_w[m], rdy_w[m], busy_w[m],
                        par_w[m], pv, pe, ps, pr, pb, pp);
            end
         end
         if (v.rst) begin
            mq[m].delete(); gap_left[m] = 0; mfirst[m] = 0; mpar[m] = 0;
         end else begin
            xf = pv && v.rdy;
            ac = v.vld && pr;
            if (!pv && gap_left[m] > 0) begin
               gap_left[m]--;
            end else if (xf) begin
               void'(mq[m].pop_front());
               mfirst[m] = 0;
               if (mq[m].size() == 0) gap_left[m] = (gap_of(m) > 0) ? gap_of(m) - 1 : 0;
            end
            if (ac) begin
               for (int i = 0; i < 4; i++) mq[m].push_back(nib_of(v.ins, i, m != 1));
               if (v.has)
                  for (int i = 0; i < 4; i++) mq[m].push_back(nib_of(v.imm, i, m != 1));
               mfirst[m] = 1;
               mpar[m]   = (($countones(v.ins) + (v.has ? $countones(v.imm) : 0)) % 2) == 1;
            end
         end
      end
      if (v.rst) started = 1'b1;
      prev_rst = v.rst;
      @(negedge clk);
   endtask

   initial begin
      vec_t rv;
      // A5C3, LSB first, no immediate
      rs(0);
      x(0, 1, 16'hA5C3, 0, 16'h0, 1, 0, 4'h0, 0, 1, 0, 0);
      x(0, 0, 16'h0, 0, 16'h0, 1, 1, 4'h3, 1, 0, 1, 0);
      x(0, 0, 16'h0, 0, 16'h0, 1, 1, 4'hC, 0, 0, 1, 0);
      x(0, 0, 16'h0, 0, 16'h0, 1, 1, 4'h5, 0, 0, 1, 0);
      x(0, 0, 16'h0, 0, 16'h0, 1, 1, 4'hA, 0, 1, 1, 0);
      x(0, 0, 16'h0, 0, 16'h0, 1, 0, 4'h0, 0, 1, 0, 0);
      // 1234 + BEEF, MSB first; imm/has_imm changes after accept are ignored
      rs(1);
      x(1, 1, 16'h1234, 1, 16'hBEEF, 1, 0, 4'h0, 0, 1, 0, 0);
      x(1, 0, 16'h0, 0, 16'h0, 1, 1, 4'h1, 1, 0, 1, 0);
      x(1, 0, 16'h0, 0, 16'h0, 1, 1, 4'h2, 0, 0, 1, 0);
      x(1, 0, 16'h0, 0, 16'h0, 1, 1, 4'h3, 0, 0, 1, 0);
      x(1, 0, 16'h0, 0, 16'h0, 1, 1, 4'h4, 0, 0, 1, 0);
      x(1, 0, 16'h0, 0, 16'h0, 1, 1, 4'hB, 0, 0, 1, 0);
      x(1, 0, 16'h0, 0, 16'h0, 1, 1, 4'hE, 0, 0, 1, 0);
      x(1, 0, 16'h0, 0, 16'h0, 1, 1, 4'hE, 0, 0, 1, 0);
      x(1, 0, 16'h0, 0, 16'h0, 1, 1, 4'hF, 0, 1, 1, 0);
      x(1, 0, 16'h0, 0, 16'h0, 1, 0, 4'h0, 0, 1, 0, 0);
      // Back-to-back 0001 then 0002, GAP=0
      rs(0);
      x(0, 1, 16'h0001, 0, 16'h0, 1, 0, 4'h0, 0, 1, 0, 0);
      x(0, 1, 16'h0002, 0, 16'h0, 1, 1, 4'h1, 1, 0, 1, 0);
      x(0, 1, 16'h0002, 0, 16'h0, 1, 1, 4'h0, 0, 0, 1, 0);
      x(0, 1, 16'h0002, 0, 16'h0, 1, 1, 4'h0, 0, 0, 1, 0);
      x(0, 1, 16'h0002, 0, 16'h0, 1, 1, 4'h0, 0, 1, 1, 1);
      x(0, 0, 16'h0, 0, 16'h0, 1, 1, 4'h2, 1, 0, 1, 0);
      x(0, 0, 16'h0, 0, 16'h0, 1, 1, 4'h0, 0, 0, 1, 0);
      x(0, 0, 16'h0, 0, 16'h0, 1, 1, 4'h0, 0, 0, 1, 0);
      x(0, 0, 16'h0, 0, 16'h0, 1, 1, 4'h0, 0, 1, 1, 1);
      x(0, 0, 16'h0, 0, 16'h0, 1, 0, 4'h0, 0, 1, 0, 0);
      // Stall for 3 cycles on nibble C
      rs(0);
      x(0, 1, 16'hA5C3, 0, 16'h0, 1, 0, 4'h0, 0, 1, 0, 0);
      x(0, 0, 16'h0, 0, 16'h0, 1, 1, 4'h3, 1, 0, 1, 0);
      x(0, 0, 16'h0, 0, 16'h0, 0, 1, 4'hC, 0, 0, 1, 0);
      x(0, 0, 16'h0, 0, 16'h0, 0, 1, 4'hC, 0, 0, 1, 0);
      x(0, 0, 16'h0, 0, 16'h0, 0, 1, 4'hC, 0, 0, 1, 0);
      x(0, 0, 16'h0, 0, 16'h0, 1, 1, 4'hC, 0, 0, 1, 0);
      x(0, 0, 16'h0, 0, 16'h0, 1, 1, 4'h5, 0, 0, 1, 0);
      x(0, 0, 16'h0, 0, 16'h0, 1, 1, 4'hA, 0, 1, 1, 0);
      x(0, 0, 16'h0, 0, 16'h0, 1, 0, 4'h0, 0, 1, 0, 0);
      // GAP=2 back-to-back: two vld=0 cycles between instructions
      rs(2);
      x(2, 1, 16'h0001, 0, 16'h0, 1, 0, 4'h0, 0, 1, 0, 0);
      x(2, 1, 16'h0002, 0, 16'h0, 1, 1, 4'h1, 1, 0, 1, 0);
      x(2, 1, 16'h0002, 0, 16'h0, 1, 1, 4'h0, 0, 0, 1, 0);
      x(2, 1, 16'h0002, 0, 16'h0, 1, 1, 4'h0, 0, 0, 1, 0);
      x(2, 1, 16'h0002, 0, 16'h0, 1, 1, 4'h0, 0, 0, 1, 1);
      x(2, 1, 16'h0002, 0, 16'h0, 1, 0, 4'h0, 0, 0, 1, 0);
      x(2, 1, 16'h0002, 0, 16'h0, 1, 0, 4'h0, 0, 1, 0, 0);
      x(2, 0, 16'h0, 0, 16'h0, 1, 1, 4'h2, 1, 0, 1, 0);
      x(2, 0, 16'h0, 0, 16'h0, 1, 1, 4'h0, 0, 0, 1, 0);
      x(2, 0, 16'h0, 0, 16'h0, 1, 1, 4'h0, 0, 0, 1, 0);
      x(2, 0, 16'h0, 0, 16'h0, 1, 1, 4'h0, 0, 0, 1, 1);
      x(2, 0, 16'h0, 0, 16'h0, 1, 0, 4'h0, 0, 0, 1, 0);
      x(2, 0, 16'h0, 0, 16'h0, 1, 0, 4'h0, 0, 1, 0, 0);
      // Reset at cnt=2 of the immediate stream
      rs(1);
      x(1, 1, 16'h1234, 1, 16'hBEEF, 1, 0, 4'h0, 0, 1, 0, 0);
      x(1, 0, 16'h0, 0, 16'h0, 1, 1, 4'h1, 1, 0, 1, 0);
      x(1, 0, 16'h0, 0, 16'h0, 1, 1, 4'h2, 0, 0, 1, 0);
      x(1, 0, 16'h0, 0, 16'h0, 1, 1, 4'h3, 0, 0, 1, 0);
      x(1, 0, 16'h0, 0, 16'h0, 1, 1, 4'h4, 0, 0, 1, 0);
      x(1, 0, 16'h0, 0, 16'h0, 1, 1, 4'hB, 0, 0, 1, 0);
      x(1, 0, 16'h0, 0, 16'h0, 1, 1, 4'hE, 0, 0, 1, 0);
      r(1, 1, 0, 16'h0, 0, 16'h0, 1, 1, 1, 4'hE, 0, 0, 1, 0);
      x(1, 0, 16'h0, 0, 16'h0, 1, 0, 4'h0, 0, 1, 0, 0);
      // Parity of 0007 on its last nibble
      rs(0);
      x(0, 1, 16'h0007, 0, 16'h0, 1, 0, 4'h0, 0, 1, 0, 0);
      x(0, 0, 16'h0, 0, 16'h0, 1, 1, 4'h7, 1, 0, 1, 0);
      x(0, 0, 16'h0, 0, 16'h0, 1, 1, 4'h0, 0, 0, 1, 0);
      x(0, 0, 16'h0, 0, 16'h0, 1, 1, 4'h0, 0, 0, 1, 0);
      x(0, 0, 16'h0, 0, 16'h0, 1, 1, 4'h0, 0, 1, 1, 1);
      x(0, 0, 16'h0, 0, 16'h0, 1, 0, 4'h0, 0, 1, 0, 0);

      foreach (vecs[i]) step(vecs[i], i);

      // Random traffic checked only against the model
      rs(0);
      step(vecs[vecs.size() - 1], -1);
      for (int c = 0; c < 800; c++) begin
         rv = vecs[0];
         rv.chk = 0;
         rv.rst = ($urandom_range(0, 149) == 0);
         rv.vld = $urandom_range(0, 1) == 1;
         rv.has = $urandom_range(0, 1) == 1;
         rv.rdy = $urandom_range(0, 3) != 0;
         rv.ins = 16'($urandom);
         rv.imm = 16'($urandom);
         step(rv, c);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
